mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shared main-memory controller for the cached WISC CPU. It arbitrates between I-cache miss fills, D-cache miss fills and D-cache write-through stores, all of which use one pipelined, fixed-latency main memory. For each fill it sequences the 8 word reads of a 16-byte block and streams the returned words back into the requesting cache. It sits between the two caches and the main memory, and its busy status feeds the CPU stall logic.

## Interface
- ADDR_W, 16: byte address width
- DATA_W, 16: word width
- WORDS, 8: words per cache block (block = 16 bytes)
- MEM_LAT, 4: memory read latency, issue edge to mem_valid
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- i_miss  in  1  I-cache miss request; held high until i_fill_done
- i_miss_addr  in  ADDR_W  I-cache miss byte address
- d_miss  in  1  D-cache miss request; held high until d_fill_done
- d_miss_addr  in  ADDR_W  D-cache miss byte address
- d_wr  in  1  write-through store request; held high until d_wr_ack
- d_wr_addr  in  ADDR_W  store byte address
- d_wr_data  in  DATA_W  store data
- mem_en  out  1  memory access strobe, one access per cycle
- mem_wr  out  1  memory write when mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_valid  in  1  mem_rdata valid
- fill_i_we  out  1  write fill_data into I-cache word fill_word
- fill_d_we  out  1  write fill_data into D-cache word fill_word
- fill_word  out  3  block word index of the current return
- fill_data  out  DATA_W  returned word, combinational pass-through of mem_rdata
- i_fill_done  out  1  one-cycle pulse; I-cache block complete
- d_fill_done  out  1  one-cycle pulse; D-cache block complete
- d_wr_ack  out  1  one-cycle pulse; store issued to memory
- busy  out  1  state != IDLE

## Operation
- States: IDLE, FILL_I, FILL_D, WRITE.
- IDLE arbitration, registered:
  - D side (d_miss, else d_wr) beats i_miss.
  - Exception: if last_grant == D and i_miss is high, I wins.
  - d_miss beats d_wr if both are high.
  - last_grant resets to I.
  - The winner's address and data are latched at the transition edge.
- FILL_x: block base = addr & ~0xF.
  - issue_cnt 0..7 drives mem_en=1, mem_wr=0, mem_addr = base + 2*issue_cnt, one issue per cycle.
  - recv_cnt 0..7 advances on each mem_valid.
  - fill_word = recv_cnt. fill_x_we = mem_valid in FILL_x.
  - When mem_valid and recv_cnt == 7: pulse x_fill_done, then go to IDLE next edge.
- WRITE: a single cycle with mem_en=1, mem_wr=1, mem_addr/mem_wdata from the latch, d_wr_ack=1. Go to IDLE next edge.
- mem_valid is ignored outside FILL states: no we, no counter change.
- A request dropped mid-fill is ignored; the fill runs to completion.
- Counters are 3-bit, reset to 0 on entry to each FILL state, and saturate: no issue after 8 issues.

## Timing
- Reset: state=IDLE, counters=0, last_grant=I. Every output is 0 except fill_data, which follows mem_rdata.
- Let F = the first cycle in FILL_x, i.e. one cycle after the request is seen in IDLE.
  - Issues on cycles F..F+7.
  - Returns and we on F+4..F+11.
  - Done pulse on F+11, IDLE at F+12.
  - Request seen in IDLE → done latency = 12 cycles.
- Back-to-back service: the next grant is evaluated in the IDLE cycle F+12, so the next FILL begins at F+13.
- WRITE: request seen in IDLE at T → WRITE at T+1 → IDLE at T+2.
- Reset asserted mid-fill: outputs clear immediately. Returns still in flight afterwards produce no we and no done.

## Structure
- Shared package holds:
  - the state encoding (IDLE/FILL_I/FILL_D/WRITE)
  - WORDS, MEM_LAT, BLK_MASK = 16'hFFF0
  - the grant encoding (GNT_I, GNT_D)
- One natural sub-module, blk_word_cnt: a 3-bit counter with clear, enable and a saturating "done" flag. It is instantiated twice, once for issue and once for receive.

## Test plan
- Reset: hold rst_n=0 with random inputs → every output 0; busy=0.
- i_miss, addr 0x1234, in IDLE:
  - mem_addr 0x1230,0x1232,…,0x123E on F..F+7.
  - fill_i_we on F+4..F+11 with fill_word 0..7.
  - i_fill_done single pulse on F+11; fill_d_we never asserts.
- d_wr, addr 0x0040, data 0xBEEF: one cycle of mem_en=mem_wr=1, mem_addr=0x0040, mem_wdata=0xBEEF, d_wr_ack pulse; busy low the next cycle.
- i_miss (0x0100) and d_miss (0x2008) raised together after reset:
  - D is served first, with addresses 0x2000..0x200E.
  - d_fill_done at F+11; FILL_I starts at F+13; i_fill_done at F+24.
- i_miss and d_miss held continuously, each re-raised after its done: grants alternate D, I, D, I.
- rst_n low at F+5 of a fill, released at F+6: outputs clear at once. mem_valid pulses on F+6..F+11 produce no fill_we and no done; the next request restarts at word 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared widths, state/grant encodings and block geometry.
// Rev 1.0
`default_nettype none

package mem_arbiter_pkg;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int WORDS   = 8;
  localparam int MEM_LAT = 4;

  localparam logic [15:0] BLK_MASK = 16'hFFF0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL_I = 2'd1,
    ST_FILL_D = 2'd2,
    ST_WRITE  = 2'd3
  } state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache request, fill return and main-memory bus of the arbiter.
// Rev 1.0
`default_nettype none

interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic              i_miss;
  logic [ADDR_W-1:0] i_miss_addr;
  logic              d_miss;
  logic [ADDR_W-1:0] d_miss_addr;
  logic              d_wr;
  logic [ADDR_W-1:0] d_wr_addr;
  logic [DATA_W-1:0] d_wr_data;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_valid;
  logic              fill_i_we;
  logic              fill_d_we;
  logic [2:0]        fill_word;
  logic [DATA_W-1:0] fill_data;
  logic              i_fill_done;
  logic              d_fill_done;
  logic              d_wr_ack;
  logic              busy;

  // Arbiter side
  modport master (
    input  i_miss, i_miss_addr, d_miss, d_miss_addr, d_wr, d_wr_addr, d_wr_data,
    input  mem_rdata, mem_valid,
    output mem_en, mem_wr, mem_addr, mem_wdata,
    output fill_i_we, fill_d_we, fill_word, fill_data,
    output i_fill_done, d_fill_done, d_wr_ack, busy
  );

  // Caches and memory side
  modport slave (
    output i_miss, i_miss_addr, d_miss, d_miss_addr, d_wr, d_wr_addr, d_wr_data,
    output mem_rdata, mem_valid,
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    input  fill_i_we, fill_d_we, fill_word, fill_data,
    input  i_fill_done, d_fill_done, d_wr_ack, busy
  );

endinterface

`default_nettype wire

// File: rtl/mem_arbiter_blk_word_cnt.sv
// blk_word_cnt: 3-bit block word counter with clear, enable and saturating done flag.
// Rev 1.0
`default_nettype none

module blk_word_cnt
  import mem_arbiter_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic       clr,
  input  wire logic       en,
  output logic [2:0]      cnt,
  output logic            done
);

  // done marks that all WORDS events were counted; cnt then holds at the last index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= 3'd0;
      done <= 1'b0;
    end else if (clr) begin
      cnt  <= 3'd0;
      done <= 1'b0;
    end else if (en && !done) begin
      if (cnt == 3'(WORDS - 1)) begin
        done <= 1'b1;
      end else begin
        cnt <= cnt + 3'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates I/D cache fills and write-through stores onto one pipelined memory.
// Rev 1.0
`default_nettype none

module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  wire logic     clk,
  input  wire logic     rst_n,
  mem_arbiter_if.master bus
);

  state_t            state;
  state_t            next_state;
  grant_t            last_grant;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;

  logic       in_fill;
  logic       cnt_clr;
  logic       issue_en;
  logic       recv_en;
  logic [2:0] issue_cnt;
  logic       issue_done;
  logic [2:0] recv_cnt;
  logic       recv_done;
  logic       recv_last;

  assign in_fill   = (state == ST_FILL_I) || (state == ST_FILL_D);
  assign cnt_clr   = (state == ST_IDLE);
  assign issue_en  = in_fill && !issue_done;
  assign recv_en   = in_fill && bus.mem_valid;
  assign recv_last = recv_en && (recv_cnt == 3'(WORDS - 1));

  blk_word_cnt u_issue_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (issue_en),
    .cnt   (issue_cnt),
    .done  (issue_done)
  );

  blk_word_cnt u_recv_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (recv_en),
    .cnt   (recv_cnt),
    .done  (recv_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A D-side grant yields to a waiting I-miss next time, so neither side starves
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: begin
        if (bus.i_miss && (last_grant == GNT_D)) begin
          next_state = ST_FILL_I;
        end else if (bus.d_miss) begin
          next_state = ST_FILL_D;
        end else if (bus.d_wr) begin
          next_state = ST_WRITE;
        end else if (bus.i_miss) begin
          next_state = ST_FILL_I;
        end
      end
      ST_FILL_I, ST_FILL_D: begin
        if (recv_last) begin
          next_state = ST_IDLE;
        end
      end
      ST_WRITE: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_en      = 1'b0;
    bus.mem_wr      = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    bus.fill_i_we   = 1'b0;
    bus.fill_d_we   = 1'b0;
    bus.fill_word   = 3'd0;
    bus.i_fill_done = 1'b0;
    bus.d_fill_done = 1'b0;
    bus.d_wr_ack    = 1'b0;
    bus.busy        = (state != ST_IDLE);
    if (in_fill) begin
      bus.mem_en    = issue_en;
      bus.mem_addr  = issue_en ? ((lat_addr & BLK_MASK) + ADDR_W'({issue_cnt, 1'b0})) : '0;
      bus.fill_word = recv_cnt;
    end
    if (state == ST_FILL_I) begin
      bus.fill_i_we   = bus.mem_valid;
      bus.i_fill_done = recv_last;
    end
    if (state == ST_FILL_D) begin
      bus.fill_d_we   = bus.mem_valid;
      bus.d_fill_done = recv_last;
    end
    if (state == ST_WRITE) begin
      bus.mem_en    = 1'b1;
      bus.mem_wr    = 1'b1;
      bus.mem_addr  = lat_addr;
      bus.mem_wdata = lat_data;
      bus.d_wr_ack  = 1'b1;
    end
  end

  assign bus.fill_data = bus.mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= GNT_I;
      lat_addr   <= '0;
      lat_data   <= '0;
    end else if (state == ST_IDLE) begin
      unique case (next_state)
        ST_FILL_I: begin
          last_grant <= GNT_I;
          lat_addr   <= bus.i_miss_addr;
        end
        ST_FILL_D: begin
          last_grant <= GNT_D;
          lat_addr   <= bus.d_miss_addr;
        end
        ST_WRITE: begin
          last_grant <= GNT_D;
          lat_addr   <= bus.d_wr_addr;
          lat_data   <= bus.d_wr_data;
        end
        ST_IDLE: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench with a fixed-latency memory model.
// Rev 1.0
`default_nettype none

module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mem_arbiter_if bus();

  mem_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory model: a read issued in cycle N returns in cycle N+MEM_LAT
  logic [MEM_LAT-1:0] pv = '0;
  logic [15:0]        pa [MEM_LAT];
  logic               inj_valid = 1'b0;
  logic [15:0]        inj_data = 16'h0;

  always @(posedge clk) begin
    pv[0] <= bus.mem_en && !bus.mem_wr;
    pa[0] <= bus.mem_addr;
    for (int i = 1; i < MEM_LAT; i++) begin
      pv[i] <= pv[i-1];
      pa[i] <= pa[i-1];
    end
  end

  assign bus.mem_valid = pv[MEM_LAT-1] | inj_valid;
  assign bus.mem_rdata = pv[MEM_LAT-1] ? (pa[MEM_LAT-1] ^ 16'hA5A5) : inj_data;

  task automatic clear_inputs();
    bus.i_miss = 1'b0; bus.i_miss_addr = 16'h0;
    bus.d_miss = 1'b0; bus.d_miss_addr = 16'h0;
    bus.d_wr = 1'b0;   bus.d_wr_addr = 16'h0; bus.d_wr_data = 16'h0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      bus.i_miss = 1'($urandom); bus.i_miss_addr = 16'($urandom);
      bus.d_miss = 1'($urandom); bus.d_miss_addr = 16'($urandom);
      bus.d_wr = 1'($urandom);   bus.d_wr_addr = 16'($urandom);
      bus.d_wr_data = 16'($urandom);
      inj_valid = 1'($urandom); inj_data = 16'($urandom);
      @(negedge clk);
      checks++;
      if ({bus.mem_en, bus.mem_wr, bus.fill_i_we, bus.fill_d_we, bus.i_fill_done,
           bus.d_fill_done, bus.d_wr_ack, bus.busy} !== 8'h00) begin
        errors++;
        $display("FAIL reset_ctrl c=%0d got en=%b wr=%b iwe=%b dwe=%b idn=%b ddn=%b ack=%b busy=%b exp all 0",
                 c, bus.mem_en, bus.mem_wr, bus.fill_i_we, bus.fill_d_we, bus.i_fill_done,
                 bus.d_fill_done, bus.d_wr_ack, bus.busy);
      end
      checks++;
      if (bus.mem_addr !== 16'h0 || bus.mem_wdata !== 16'h0 || bus.fill_word !== 3'd0) begin
        errors++;
        $display("FAIL reset_data c=%0d got addr=%h wdata=%h word=%0d exp 0", c,
                 bus.mem_addr, bus.mem_wdata, bus.fill_word);
      end
      checks++;
      if (bus.fill_data !== bus.mem_rdata) begin
        errors++;
        $display("FAIL reset_fill_data got %h exp %h", bus.fill_data, bus.mem_rdata);
      end
    end
    @(posedge clk); #1;
    clear_inputs();
    inj_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_i_fill();
    logic        e_en, e_we;
    logic [15:0] e_addr;
    @(posedge clk); #1;
    bus.i_miss = 1'b1; bus.i_miss_addr = 16'h1234;
    for (int k = 0; k <= 13; k++) begin
      @(posedge clk); #1;
      if (k == 12) bus.i_miss = 1'b0;
      @(negedge clk);
      e_en = (k <= 7);
      e_addr = e_en ? 16'h1230 + 16'(2 * k) : 16'h0;
      e_we = (k >= 4 && k <= 11);
      checks++;
      if (bus.mem_en !== e_en || bus.mem_wr !== 1'b0 || bus.mem_addr !== e_addr) begin
        errors++;
        $display("FAIL ifill_issue k=%0d got en=%b wr=%b addr=%h exp en=%b wr=0 addr=%h",
                 k, bus.mem_en, bus.mem_wr, bus.mem_addr, e_en, e_addr);
      end
      checks++;
      if (bus.fill_i_we !== e_we || bus.fill_d_we !== 1'b0 || bus.i_fill_done !== (k == 11)) begin
        errors++;
        $display("FAIL ifill_we k=%0d got iwe=%b dwe=%b done=%b exp iwe=%b dwe=0 done=%b",
                 k, bus.fill_i_we, bus.fill_d_we, bus.i_fill_done, e_we, (k == 11));
      end
      if (e_we) begin
        checks++;
        if (bus.fill_word !== 3'(k - 4) || bus.fill_data !== ((16'h1230 + 16'(2 * (k - 4))) ^ 16'hA5A5)) begin
          errors++;
          $display("FAIL ifill_word k=%0d got word=%0d data=%h exp word=%0d data=%h", k,
                   bus.fill_word, bus.fill_data, k - 4, (16'h1230 + 16'(2 * (k - 4))) ^ 16'hA5A5);
        end
      end
      checks++;
      if (bus.busy !== (k <= 11)) begin
        errors++;
        $display("FAIL ifill_busy k=%0d got %b exp %b", k, bus.busy, (k <= 11));
      end
    end
  endtask

  task automatic test_write();
    @(posedge clk); #1;
    bus.d_wr = 1'b1; bus.d_wr_addr = 16'h0040; bus.d_wr_data = 16'hBEEF;
    @(posedge clk); #1;
    bus.d_wr = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mem_en !== 1'b1 || bus.mem_wr !== 1'b1 || bus.mem_addr !== 16'h0040 ||
        bus.mem_wdata !== 16'hBEEF || bus.d_wr_ack !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL write_cycle got en=%b wr=%b addr=%h wdata=%h ack=%b busy=%b exp 1 1 0040 BEEF 1 1",
               bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.d_wr_ack, bus.busy);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.d_wr_ack !== 1'b0 || bus.mem_en !== 1'b0) begin
      errors++;
      $display("FAIL write_after got busy=%b ack=%b en=%b exp 0 0 0", bus.busy, bus.d_wr_ack, bus.mem_en);
    end
  endtask

  task automatic test_both();
    logic        e_en, e_dwe, e_iwe;
    logic [15:0] e_addr;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus.i_miss = 1'b1; bus.i_miss_addr = 16'h0100;
    bus.d_miss = 1'b1; bus.d_miss_addr = 16'h2008;
    for (int k = 0; k <= 25; k++) begin
      @(posedge clk); #1;
      if (k == 12) bus.d_miss = 1'b0;
      if (k == 25) bus.i_miss = 1'b0;
      @(negedge clk);
      e_en = (k <= 7) || (k >= 13 && k <= 20);
      e_addr = (k <= 7) ? 16'h2000 + 16'(2 * k) :
               (k >= 13 && k <= 20) ? 16'h0100 + 16'(2 * (k - 13)) : 16'h0;
      e_dwe = (k >= 4 && k <= 11);
      e_iwe = (k >= 17 && k <= 24);
      checks++;
      if (bus.mem_en !== e_en || bus.mem_addr !== e_addr) begin
        errors++;
        $display("FAIL both_issue k=%0d got en=%b addr=%h exp en=%b addr=%h",
                 k, bus.mem_en, bus.mem_addr, e_en, e_addr);
      end
      checks++;
      if (bus.fill_d_we !== e_dwe || bus.fill_i_we !== e_iwe ||
          bus.d_fill_done !== (k == 11) || bus.i_fill_done !== (k == 24)) begin
        errors++;
        $display("FAIL both_fill k=%0d got dwe=%b iwe=%b ddn=%b idn=%b exp %b %b %b %b", k,
                 bus.fill_d_we, bus.fill_i_we, bus.d_fill_done, bus.i_fill_done,
                 e_dwe, e_iwe, (k == 11), (k == 24));
      end
      checks++;
      if (bus.busy !== !(k == 12 || k == 25)) begin
        errors++;
        $display("FAIL both_busy k=%0d got %b exp %b", k, bus.busy, !(k == 12 || k == 25));
      end
    end
  endtask

  task automatic test_alternate();
    @(posedge clk); #1;
    bus.i_miss = 1'b1; bus.i_miss_addr = 16'h4000;
    bus.d_miss = 1'b1; bus.d_miss_addr = 16'h3000;
    for (int k = 0; k <= 52; k++) begin
      @(posedge clk); #1;
      if (k == 51) begin
        bus.i_miss = 1'b0;
        bus.d_miss = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (bus.d_fill_done !== (k == 11 || k == 37) || bus.i_fill_done !== (k == 24 || k == 50)) begin
        errors++;
        $display("FAIL alt_done k=%0d got ddn=%b idn=%b exp %b %b", k, bus.d_fill_done,
                 bus.i_fill_done, (k == 11 || k == 37), (k == 24 || k == 50));
      end
      checks++;
      if (bus.busy !== !(k == 12 || k == 25 || k == 38 || k >= 51)) begin
        errors++;
        $display("FAIL alt_busy k=%0d got %b exp %b", k, bus.busy,
                 !(k == 12 || k == 25 || k == 38 || k >= 51));
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    @(posedge clk); #1;
    bus.i_miss = 1'b1; bus.i_miss_addr = 16'h0500;
    for (int k = 0; k <= 12; k++) begin
      @(posedge clk); #1;
      if (k == 5) begin
        rst_n = 1'b0;
        bus.i_miss = 1'b0;
      end
      if (k == 6) rst_n = 1'b1;
      inj_valid = (k >= 6 && k <= 11);
      inj_data = 16'h5A00 + 16'(k);
      @(negedge clk);
      if (k >= 5) begin
        checks++;
        if (bus.busy !== 1'b0 || bus.mem_en !== 1'b0 || bus.fill_i_we !== 1'b0 ||
            bus.fill_d_we !== 1'b0 || bus.i_fill_done !== 1'b0 || bus.fill_word !== 3'd0) begin
          errors++;
          $display("FAIL rstmid k=%0d got busy=%b en=%b iwe=%b dwe=%b idn=%b word=%0d exp all 0", k,
                   bus.busy, bus.mem_en, bus.fill_i_we, bus.fill_d_we, bus.i_fill_done, bus.fill_word);
        end
      end
    end
    @(posedge clk); #1;
    bus.i_miss = 1'b1; bus.i_miss_addr = 16'h0600;
    for (int k = 0; k <= 12; k++) begin
      @(posedge clk); #1;
      if (k == 12) bus.i_miss = 1'b0;
      @(negedge clk);
      if (k == 0) begin
        checks++;
        if (bus.mem_en !== 1'b1 || bus.mem_addr !== 16'h0600) begin
          errors++;
          $display("FAIL restart_issue got en=%b addr=%h exp 1 0600", bus.mem_en, bus.mem_addr);
        end
      end
      if (k == 4) begin
        checks++;
        if (bus.fill_i_we !== 1'b1 || bus.fill_word !== 3'd0 || bus.fill_data !== (16'h0600 ^ 16'hA5A5)) begin
          errors++;
          $display("FAIL restart_word0 got we=%b word=%0d data=%h exp 1 0 %h", bus.fill_i_we,
                   bus.fill_word, bus.fill_data, 16'h0600 ^ 16'hA5A5);
        end
      end
      checks++;
      if (bus.i_fill_done !== (k == 11)) begin
        errors++;
        $display("FAIL restart_done k=%0d got %b exp %b", k, bus.i_fill_done, (k == 11));
      end
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_i_fill();
    test_write();
    test_both();
    test_alternate();
    test_reset_mid_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
